// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the serial instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned WORD_W               = 32;
  localparam int unsigned COUNT_W              = 16;

  typedef enum logic [1:0] {
    HDR_HI = 2'd0,
    HDR_LO = 2'd1,
    WORD   = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, bit timer, LSB-first shift register,
// one-cycle byte strobe and a one-cycle framing-error strobe.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  rx_state_t        state, state_nx;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic tick_half, tick_full;
  logic restart_c, sample_c, stop_done_c;

  assign tick_half = (cnt == CNT_W'(HALF - 1));
  assign tick_full = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign rx_byte   = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_nx = RX_START;
      RX_START: if (tick_half) state_nx = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) state_nx = RX_STOP;
      RX_STOP:  if (tick_full) state_nx = RX_IDLE;
      default:  state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    restart_c   = 1'b0;
    sample_c    = 1'b0;
    stop_done_c = 1'b0;
    case (state)
      RX_START: restart_c = tick_half;
      RX_DATA: begin
        restart_c = tick_full;
        sample_c  = tick_full;
      end
      RX_STOP: begin
        restart_c   = tick_full;
        stop_done_c = tick_full;
      end
      default: ;
    endcase
  end

  // Two-stage synchronizer plus a previous-sample flop for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= (state == RX_IDLE || restart_c) ? '0 : cnt + CNT_W'(1);
      byte_valid <= stop_done_c && rx_sync;
      frame_err  <= stop_done_c && !rx_sync;
      if (state == RX_IDLE) bit_idx <= '0;
      if (sample_c) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a 16-bit word count and big-endian 32-bit words from the
// UART and writes them to instruction memory, holding the CPU until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rx,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        Hold,
  output logic        Done,
  output logic        FramingError
);

  loader_state_t      state, state_nx;
  logic               byte_valid, frame_err;
  logic [7:0]         rx_byte;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] wr_ptr;
  logic [1:0]         byte_idx;
  logic [23:0]        asm_word;

  logic abort_c, load_hi_c, load_lo_c, word_byte_c, write_c;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (Clk),
    .rst        (Reset),
    .rx         (Rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= HDR_HI;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort_c) begin
      state_nx = HDR_HI;
    end else if (byte_valid) begin
      case (state)
        HDR_HI:  state_nx = HDR_LO;
        HDR_LO:  state_nx = ({count[15:8], rx_byte} == 16'd0) ? DONE : WORD;
        WORD:    if (write_c && count == 16'd1) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    abort_c     = frame_err && (state != DONE);
    load_hi_c   = byte_valid && (state == HDR_HI);
    load_lo_c   = byte_valid && (state == HDR_LO);
    word_byte_c = byte_valid && (state == WORD);
    write_c     = word_byte_c && (byte_idx == 2'd3);
  end

  // A framing error drops the partial stream; the next header restarts at address 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
      Hold         <= 1'b1;
      Done         <= 1'b0;
      FramingError <= 1'b0;
      count        <= '0;
      wr_ptr       <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
    end else begin
      WriteEnable <= write_c;
      Hold        <= (state != DONE);
      Done        <= (state == DONE);
      if (abort_c) begin
        FramingError <= 1'b1;
        count        <= '0;
        wr_ptr       <= '0;
        byte_idx     <= '0;
      end else begin
        if (load_hi_c) count[15:8] <= rx_byte;
        if (load_lo_c) begin
          count[7:0] <= rx_byte;
          byte_idx   <= '0;
        end
        if (word_byte_c) begin
          asm_word <= {asm_word[15:0], rx_byte};
          byte_idx <= byte_idx + 2'd1;
        end
        if (write_c) begin
          WriteData    <= {asm_word, rx_byte};
          WriteAddress <= {14'd0, wr_ptr, 2'b00};
          wr_ptr       <= wr_ptr + 16'd1;
          count        <= count - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// sent, and a negedge monitor checks each WriteEnable pulse against the queue.
module tb_imem_loader;

  localparam int unsigned CPB = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        Clk;
  logic        Reset;
  logic        Rx;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        Hold;
  logic        Done;
  logic        FramingError;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   expect_final = 1'b0;
  logic we_prev = 1'b0;

  imem_loader #(.CLKS_PER_BIT(CPB)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Rx           (Rx),
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .Hold         (Hold),
    .Done         (Done),
    .FramingError (FramingError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop an expected write on every strobe; after the final write of a
  // program, Done must be high and Hold low on the following cycle.
  always @(negedge Clk) begin
    if (we_prev && expect_final && exp_q.size() == 0) begin
      check("done_hold_after_last_write", {30'd0, Done, Hold}, 32'h2);
      expect_final = 1'b0;
    end
    if (WriteEnable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", WriteAddress, WriteData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", WriteAddress, e.addr);
        check("write_data", WriteData, e.data);
      end
    end
    we_prev = WriteEnable;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge Clk) Rx = 1'b0;
    repeat (CPB - 1) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk) Rx = b[i];
      repeat (CPB - 1) @(negedge Clk);
    end
    @(negedge Clk) Rx = stop_bit;
    repeat (CPB - 1) @(negedge Clk);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input bit last);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
    if (last) expect_final = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !expect_final) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %0d writes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},   {31'd0, WriteEnable}, 32'd0);
    check({tag, "_addr"}, WriteAddress, 32'd0);
    check({tag, "_data"}, WriteData, 32'd0);
    check({tag, "_hold"}, {31'd0, Hold}, 32'd1);
    check({tag, "_done"}, {31'd0, Done}, 32'd0);
    check({tag, "_ferr"}, {31'd0, FramingError}, 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge Clk) Reset = 1'b1;
    Rx = 1'b1;
    repeat (2) @(negedge Clk);
    check_reset_outputs(tag);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    Rx    = 1'b1;
    repeat (3) @(negedge Clk);
    check_reset_outputs("por");
    Reset = 1'b0;
    repeat (4) @(negedge Clk);

    // Nominal two-word load.
    expect_write(32'h0, 32'h2008_0005, 1'b0);
    expect_write(32'h4, 32'hAC08_0004, 1'b1);
    send_seq('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04});
    wait_drain("nominal_drain");
    check("nominal_done", {31'd0, Done}, 32'd1);

    // Trailing bytes after Done are ignored.
    send_seq('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    repeat (20) @(negedge Clk);
    check("trailing_done", {31'd0, Done}, 32'd1);
    check("trailing_hold", {31'd0, Hold}, 32'd0);

    // Empty program.
    pulse_reset("rst1");
    send_byte(8'h00);
    repeat (4) @(negedge Clk);
    check("empty_mid_done", {31'd0, Done}, 32'd0);
    send_byte(8'h00);
    repeat (6) @(negedge Clk);
    check("empty_done", {31'd0, Done}, 32'd1);
    check("empty_hold", {31'd0, Hold}, 32'd0);

    // Framing error aborts, then a clean reload from address 0.
    pulse_reset("rst2");
    send_seq('{8'h00, 8'h01});
    send_byte(8'h12, 1'b0);
    @(negedge Clk) Rx = 1'b1;
    repeat (10) @(negedge Clk);
    check("ferr_flag", {31'd0, FramingError}, 32'd1);
    check("ferr_hold", {31'd0, Hold}, 32'd1);
    check("ferr_done", {31'd0, Done}, 32'd0);
    expect_write(32'h0, 32'hDEAD_BEEF, 1'b1);
    send_seq('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    wait_drain("ferr_drain");
    check("ferr_reload_done", {31'd0, Done}, 32'd1);
    check("ferr_sticky", {31'd0, FramingError}, 32'd1);

    // One-cycle low glitch mid-word must not inject a byte.
    pulse_reset("rst3");
    expect_write(32'h0, 32'hCAFE_BABE, 1'b1);
    send_seq('{8'h00, 8'h01, 8'hCA, 8'hFE});
    @(negedge Clk) Rx = 1'b0;
    @(negedge Clk) Rx = 1'b1;
    repeat (12) @(negedge Clk);
    send_seq('{8'hBA, 8'hBE});
    wait_drain("glitch_drain");
    check("glitch_done", {31'd0, Done}, 32'd1);

    // Reset mid-word discards the partial word.
    pulse_reset("rst4");
    send_seq('{8'h00, 8'h01, 8'h11, 8'h22});
    pulse_reset("rst_midword");
    expect_write(32'h0, 32'h3344_5566, 1'b1);
    send_seq('{8'h00, 8'h01, 8'h33, 8'h44, 8'h55, 8'h66});
    wait_drain("midword_drain");
    check("midword_done", {31'd0, Done}, 32'd1);
    check("midword_hold", {31'd0, Hold}, 32'd0);

    repeat (10) @(negedge Clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
